load_store_unit: RTL and testbench

- Sits between the core execute stage (ALU address, rs2 data, funct3, load/store control) and the data-side memory bus.
- Turns LB/LH/LW/LBU/LHU/SB/SH/SW into a word-aligned valid/ready bus transaction with byte enables. Extracts and extends load data.
- Stalls the core while the access is in flight, and flags misaligned, illegal-size and timed-out accesses.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns LB/LH/LW/LBU/LHU/SB/SH/SW into a word-aligned
// valid/ready bus access with byte enables, extends load data, flags errors.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  req_ready_o,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  err_o,
  output logic [1:0]            err_cause_o,
  output logic                  bus_valid_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_be_o,
  input  logic                  bus_ready_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_cause;

  logic                  w_illegal, w_misal, w_timeout;
  logic [DATA_WIDTH-1:0] w_shift, w_load, w_wdata;
  logic [3:0]            w_be;

  assign w_illegal = req_we_i ? (req_funct3_i > 3'b010)
                              : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
  assign w_misal   = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                     (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  // Counter holds the number of REQ/WAIT cycles already spent; the last allowed one aborts.
  assign w_timeout = (r_cnt == CNT_LAST);

  assign w_shift = bus_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (r_we) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = r_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = (w_illegal || w_misal) ? S_ERR : S_REQ;
      S_REQ: begin
        if (bus_ready_i)    w_next = r_we ? S_DONE : S_WAIT;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WAIT: if (bus_rvalid_i || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cause  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_addr   <= req_addr_i;
          r_we     <= req_we_i;
          r_funct3 <= req_funct3_i;
          r_wdata  <= req_wdata_i;
          r_rdata  <= '0;
          r_cnt    <= '0;
          r_cause  <= w_illegal ? 2'b10 : (w_misal ? 2'b01 : 2'b00);
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (!bus_ready_i && w_timeout) r_cause <= 2'b11;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus_rvalid_i)   r_rdata <= w_load;
          else if (w_timeout) r_cause <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign stall_o     = (r_state == S_IDLE && req_valid_i) || r_state == S_REQ || r_state == S_WAIT;
  assign rsp_valid_o = (r_state == S_DONE) || (r_state == S_ERR);
  assign rsp_rdata_o = (r_state == S_DONE) ? r_rdata : '0;
  assign err_o       = (r_state == S_ERR) || (r_state == S_DONE && r_cause != 2'b00);
  assign err_cause_o = rsp_valid_o ? r_cause : 2'b00;

  assign bus_valid_o = (r_state == S_REQ);
  assign bus_we_o    = bus_valid_o && r_we;
  assign bus_addr_o  = bus_valid_o ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus_be_o    = bus_valid_o ? w_be : 4'b0000;
  assign bus_wdata_o = bus_valid_o ? w_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error causes, timeout, reset abort.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, stall_o, rsp_valid_o, err_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  err_cause_o;
  logic        bus_valid_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ready_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int n_err = 0;
  int n_chk = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .stall_o(stall_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .err_o(err_o), .err_cause_o(err_cause_o),
    .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ready_i(bus_ready_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = 32'h5555_5555;
    #1;
    chk({tag, ".idle_stall"}, 32'(stall_o), 32'd1);
    chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0; bus_ready_i = 1'b1;
    #1;
    chk({tag, ".req_valid"}, 32'(bus_valid_o), 32'd1);
    chk({tag, ".req_addr"}, bus_addr_o, exp_addr);
    chk({tag, ".req_be"}, 32'(bus_be_o), 32'hF);
    chk({tag, ".req_we"}, 32'(bus_we_o), 32'd0);
    chk({tag, ".req_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, ".req_stall"}, 32'(stall_o), 32'd1);
    tick();
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = rd;
    #1;
    chk({tag, ".wait_stall"}, 32'(stall_o), 32'd1);
    chk({tag, ".wait_busv"}, 32'(bus_valid_o), 32'd0);
    chk({tag, ".wait_rsp"}, 32'(rsp_valid_o), 32'd0);
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk({tag, ".done_rsp"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".done_data"}, rsp_rdata_o, exp_data);
    chk({tag, ".done_err"}, 32'(err_o), 32'd0);
    chk({tag, ".done_cause"}, 32'(err_cause_o), 32'd0);
    chk({tag, ".done_stall"}, 32'(stall_o), 32'd0);
    tick();
    #1;
    chk({tag, ".idle_rsp"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, ".idle_data"}, rsp_rdata_o, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd;
    #1;
    chk({tag, ".idle_stall"}, 32'(stall_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      bus_ready_i = (i == delay);
      #1;
      chk({tag, ".req_valid"}, 32'(bus_valid_o), 32'd1);
      chk({tag, ".req_we"}, 32'(bus_we_o), 32'd1);
      chk({tag, ".req_addr"}, bus_addr_o, exp_addr);
      chk({tag, ".req_be"}, 32'(bus_be_o), 32'(exp_be));
      chk({tag, ".req_wdata"}, bus_wdata_o, exp_wdata);
      chk({tag, ".req_stall"}, 32'(stall_o), 32'd1);
      tick();
    end
    bus_ready_i = 1'b0;
    #1;
    chk({tag, ".done_rsp"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".done_data"}, rsp_rdata_o, 32'd0);
    chk({tag, ".done_err"}, 32'(err_o), 32'd0);
    chk({tag, ".done_busv"}, 32'(bus_valid_o), 32'd0);
    tick();
    #1;
    chk({tag, ".idle_rsp"}, 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [1:0] cause);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = 32'hA5A5_A5A5;
    #1;
    chk({tag, ".idle_stall"}, 32'(stall_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    #1;
    chk({tag, ".err_rsp"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".err_err"}, 32'(err_o), 32'd1);
    chk({tag, ".err_cause"}, 32'(err_cause_o), 32'(cause));
    chk({tag, ".err_stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".err_busv"}, 32'(bus_valid_o), 32'd0);
    chk({tag, ".err_data"}, rsp_rdata_o, 32'd0);
    tick();
    #1;
    chk({tag, ".idle_err"}, 32'(err_o), 32'd0);
    chk({tag, ".idle_cause"}, 32'(err_cause_o), 32'd0);
    chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = '0; req_wdata_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.rsp", 32'(rsp_valid_o), 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.cause", 32'(err_cause_o), 32'd0);
    chk("rst.busv", 32'(bus_valid_o), 32'd0);
    chk("rst.addr", bus_addr_o, 32'd0);
    chk("rst.be", 32'(bus_be_o), 32'd0);

    do_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF);
    do_load("lb13", 3'b000, 32'h13, 32'h80FF_1234, 32'h10, 32'hFFFF_FF80);
    do_load("lbu13", 3'b100, 32'h13, 32'h80FF_1234, 32'h10, 32'h0000_0080);
    do_load("lh12", 3'b001, 32'h12, 32'h80FF_1234, 32'h10, 32'hFFFF_80FF);
    do_load("lhu12", 3'b101, 32'h12, 32'h80FF_1234, 32'h10, 32'h0000_80FF);
    do_load("lb11", 3'b000, 32'h11, 32'h80FF_1234, 32'h10, 32'h0000_0012);

    do_store("sh22", 3'b001, 32'h22, 32'h0000_ABCD, 3, 32'h20, 4'b1100, 32'hABCD_ABCD);
    do_store("sb11", 3'b000, 32'h11, 32'hFFFF_FF5A, 0, 32'h10, 4'b0010, 32'h5A5A_5A5A);
    do_store("sh40", 3'b001, 32'h40, 32'h1234_5678, 1, 32'h40, 4'b0011, 32'h5678_5678);

    do_err("lw21", 1'b0, 3'b010, 32'h21, 2'b01);
    do_err("sb_f3_011", 1'b1, 3'b011, 32'h20, 2'b10);
    do_err("lh21_mis", 1'b0, 3'b001, 32'h21, 2'b01);
    do_err("ld_f3_110_mis", 1'b0, 3'b110, 32'h21, 2'b10);
    do_err("sw22", 1'b1, 3'b010, 32'h22, 2'b01);

    // Timeout: bus never ready; rvalid pulses during REQ must be ignored
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h40;
    tick();
    req_valid_i = 1'b0; bus_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_1111;
      #1;
      chk("tmo.req_valid", 32'(bus_valid_o), 32'd1);
      chk("tmo.req_rsp", 32'(rsp_valid_o), 32'd0);
      tick();
    end
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #1;
    chk("tmo.rsp", 32'(rsp_valid_o), 32'd1);
    chk("tmo.err", 32'(err_o), 32'd1);
    chk("tmo.cause", 32'(err_cause_o), 32'd3);
    chk("tmo.data", rsp_rdata_o, 32'd0);
    chk("tmo.busv", 32'(bus_valid_o), 32'd0);
    tick();
    #1;
    chk("tmo.idle_ready", 32'(req_ready_o), 32'd1);
    chk("tmo.idle_rsp", 32'(rsp_valid_o), 32'd0);

    // Reset while waiting for read data
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h50;
    tick();
    req_valid_i = 1'b0; bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    #1;
    chk("rstw.wait_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rstw.ready", 32'(req_ready_o), 32'd1);
    chk("rstw.rsp", 32'(rsp_valid_o), 32'd0);
    chk("rstw.busv", 32'(bus_valid_o), 32'd0);
    chk("rstw.stall", 32'(stall_o), 32'd0);
    chk("rstw.err", 32'(err_o), 32'd0);
    tick();
    #1;
    chk("rstw.rsp2", 32'(rsp_valid_o), 32'd0);
    do_store("sw30", 3'b010, 32'h30, 32'h1234_5678, 0, 32'h30, 4'b1111, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
